// File: rtl/riscv_mem_pkg.sv
// Shared types and MemOp encodings for the unified-memory arbiter.
package riscv_mem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IF = 2'd1,
        ST_WAIT_D  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend,
// and misalignment detection. Request side and response side are independent.
import riscv_mem_pkg::*;

module mem_lsu_align (
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_rop,
    input  logic [1:0]  i_rlo,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_mis,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;

    assign w_lane = i_rdata >> {i_rlo, 3'b000};

    // Request side; reserved encodings fall through to word behaviour.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_mis   = (i_lo != 2'b00);
        case (i_op)
            MOP_B, MOP_BU: begin
                o_be    = 4'b0001 << i_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_mis   = 1'b0;
            end
            MOP_H, MOP_HU: begin
                o_be    = 4'b0011 << i_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_mis   = i_lo[0];
            end
            default: ;
        endcase
    end

    // Response side: lane already shifted down, then sign or zero extend.
    always_comb begin
        o_rdata = i_rdata;
        case (i_rop)
            MOP_B:   o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
            MOP_BU:  o_rdata = {24'h000000, w_lane[7:0]};
            MOP_H:   o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
            MOP_HU:  o_rdata = {16'h0000, w_lane[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Data wins unless the previous grant was data and a fetch is waiting.
import riscv_mem_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [2:0]        d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    owner_t            r_last;
    logic [2:0]        r_op;
    logic [1:0]        r_lo;
    logic              r_we;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;
    logic              r_d_err;

    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_mis;
    logic [31:0]       w_ld;
    logic              w_idle;
    logic              w_d_any;
    logic              w_d_req;
    logic              w_if_req;
    logic              w_mis_hit;
    logic              w_pick_d;
    logic              w_pick_if;
    logic              w_unused;

    // Fetch addresses are always word aligned; the low bits carry no information.
    assign w_unused = ^if_addr[1:0];

    mem_lsu_align u_align (
        .i_op    (d_op),
        .i_lo    (d_addr[1:0]),
        .i_wdata (d_wdata),
        .i_rop   (r_op),
        .i_rlo   (r_lo),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_mis   (w_mis),
        .o_rdata (w_ld)
    );

    // A request whose completion pulse is currently high is the one just served.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_d_any   = d_read | d_write;
    assign w_d_req   = w_d_any & ~r_d_valid;
    assign w_if_req  = if_req & ~r_if_valid;
    assign w_mis_hit = w_idle & w_d_req & w_mis;
    assign w_pick_d  = w_idle & w_d_req & ~w_mis & ~(w_if_req & (r_last == OWN_D));
    assign w_pick_if = w_idle & w_if_req & ~w_pick_d;

    assign if_stall  = if_req & ~r_if_valid;
    assign d_stall   = w_d_any & ~r_d_valid;

    // Memory request fields follow the selected port while idle, zero otherwise.
    always_comb begin
        mem_req   = w_pick_d | w_pick_if;
        mem_we    = w_pick_d & d_write;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_pick_d) begin
            mem_be   = w_be;
            mem_addr = {d_addr[ADDR_W-1:2], 2'b00};
            if (d_write)
                mem_wdata = w_wdata;
        end else if (w_pick_if) begin
            mem_be   = 4'b1111;
            mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
        end
    end

    // Transaction sequencing with registered completion outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last     <= OWN_IF;
            r_op       <= 3'b000;
            r_lo       <= 2'b00;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_mis_hit) begin
                        r_d_valid <= 1'b1;
                        r_d_err   <= 1'b1;
                        r_d_rdata <= '0;
                    end
                    if (mem_gnt && w_pick_d) begin
                        r_state <= ST_WAIT_D;
                        r_last  <= OWN_D;
                        r_op    <= d_op;
                        r_lo    <= d_addr[1:0];
                        r_we    <= d_write;
                    end else if (mem_gnt && w_pick_if) begin
                        r_state <= ST_WAIT_IF;
                        r_last  <= OWN_IF;
                    end
                end
                ST_WAIT_IF: begin
                    if (mem_rvalid) begin
                        r_if_rdata <= mem_rdata;
                        r_if_valid <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WAIT_D: begin
                    if (mem_rvalid) begin
                        r_d_rdata <= r_we ? '0 : w_ld;
                        r_d_valid <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_rdata = r_if_rdata;
    assign if_valid = r_if_valid;
    assign d_rdata  = r_d_rdata;
    assign d_valid  = r_d_valid;
    assign d_err    = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the memory side is driven by hand per step.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_read;
    logic        d_write;
    logic [2:0]  d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_op       (d_op),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_valid    (d_valid),
        .d_err      (d_err),
        .d_stall    (d_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".if_rdata"},  if_rdata, 32'h0);
        chk({tag, ".d_rdata"},   d_rdata, 32'h0);
        chk({tag, ".if_valid"},  {31'b0, if_valid}, 32'h0);
        chk({tag, ".d_valid"},   {31'b0, d_valid}, 32'h0);
        chk({tag, ".d_err"},     {31'b0, d_err}, 32'h0);
        chk({tag, ".mem_req"},   {31'b0, mem_req}, 32'h0);
        chk({tag, ".mem_we"},    {31'b0, mem_we}, 32'h0);
        chk({tag, ".mem_be"},    {28'b0, mem_be}, 32'h0);
        chk({tag, ".mem_addr"},  mem_addr, 32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // One data access with a one-cycle memory response.
    task automatic d_txn(input string tag, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mrdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        d_read  = ~wr;
        d_write = wr;
        d_op    = op;
        d_addr  = addr;
        d_wdata = wdata;
        mem_gnt = 1'b1;
        #1;
        chk({tag, ".req"},   {31'b0, mem_req}, 32'h1);
        chk({tag, ".we"},    {31'b0, mem_we}, {31'b0, wr});
        chk({tag, ".be"},    {28'b0, mem_be}, {28'b0, exp_be});
        chk({tag, ".addr"},  mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".wdata"}, mem_wdata, exp_wdata);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = mrdata;
        #1;
        chk({tag, ".wait_stall"}, {31'b0, d_stall}, 32'h1);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk({tag, ".valid"}, {31'b0, d_valid}, 32'h1);
        chk({tag, ".err"},   {31'b0, d_err}, 32'h0);
        chk({tag, ".rdata"}, d_rdata, exp_rdata);
        d_read  = 1'b0;
        d_write = 1'b0;
        tick();
    endtask

    initial begin
        reset      = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_op       = 3'b000;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b1;
        tick();

        // Fetch only: 3-cycle access
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        mem_gnt = 1'b1;
        #1;
        chk("fetch.req",    {31'b0, mem_req}, 32'h1);
        chk("fetch.addr",   mem_addr, 32'h0000_0100);
        chk("fetch.be",     {28'b0, mem_be}, 32'hF);
        chk("fetch.we",     {31'b0, mem_we}, 32'h0);
        chk("fetch.stall0", {31'b0, if_stall}, 32'h1);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0050_0093;
        #1;
        chk("fetch.stall1", {31'b0, if_stall}, 32'h1);
        chk("fetch.wreq",   {31'b0, mem_req}, 32'h0);
        chk("fetch.nvalid", {31'b0, if_valid}, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("fetch.valid",  {31'b0, if_valid}, 32'h1);
        chk("fetch.rdata",  if_rdata, 32'h0050_0093);
        chk("fetch.stall2", {31'b0, if_stall}, 32'h0);
        chk("fetch.noregrant", {31'b0, mem_req}, 32'h0);
        if_req = 1'b0;
        tick();
        #1;
        chk("fetch.pulse", {31'b0, if_valid}, 32'h0);

        // Stores and loads
        d_txn("sb",  1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB, 32'h0,
              4'b1000, 32'hABAB_ABAB, 32'h0);
        d_txn("sh",  1'b1, 3'b001, 32'h0000_0302, 32'h0000_1234, 32'h0,
              4'b1100, 32'h1234_1234, 32'h0);
        d_txn("lh",  1'b0, 3'b001, 32'h0000_0302, 32'h0, 32'h8001_1234,
              4'b1100, 32'h0, 32'hFFFF_8001);
        d_txn("lhu", 1'b0, 3'b101, 32'h0000_0302, 32'h0, 32'h8001_1234,
              4'b1100, 32'h0, 32'h0000_8001);
        d_txn("lb",  1'b0, 3'b000, 32'h0000_0301, 32'h0, 32'h0000_8000,
              4'b0010, 32'h0, 32'hFFFF_FF80);
        d_txn("lbu", 1'b0, 3'b100, 32'h0000_0301, 32'h0, 32'h0000_8000,
              4'b0010, 32'h0, 32'h0000_0080);
        d_txn("lw",  1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'hCAFE_F00D,
              4'b1111, 32'h0, 32'hCAFE_F00D);

        // Reset while waiting for a data response
        d_read  = 1'b1;
        d_op    = 3'b010;
        d_addr  = 32'h0000_0500;
        mem_gnt = 1'b1;
        #1;
        chk("rst.req", {31'b0, mem_req}, 32'h1);
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("rst.wait", {31'b0, d_stall}, 32'h1);
        reset  = 1'b0;
        d_read = 1'b0;
        #1;
        chk_zero("rst.asserted");
        tick();
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk_zero("rst.late_rvalid");
        tick();
        #1;
        chk("rst.no_valid", {31'b0, d_valid}, 32'h0);

        // Contention: D, IF, D
        if_req  = 1'b1;
        if_addr = 32'h0000_0104;
        d_read  = 1'b1;
        d_op    = 3'b010;
        d_addr  = 32'h0000_0600;
        mem_gnt = 1'b1;
        #1;
        chk("arb.first_addr", mem_addr, 32'h0000_0600);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        #1;
        chk("arb.wait1", {31'b0, mem_req}, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        d_addr     = 32'h0000_0604;
        mem_gnt    = 1'b1;
        #1;
        chk("arb.d1_valid", {31'b0, d_valid}, 32'h1);
        chk("arb.d1_rdata", d_rdata, 32'h1111_1111);
        chk("arb.if_req",   {31'b0, mem_req}, 32'h1);
        chk("arb.if_addr",  mem_addr, 32'h0000_0104);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2222_2222;
        #1;
        chk("arb.d_stall", {31'b0, d_stall}, 32'h1);
        tick();
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        if_req     = 1'b0;
        #1;
        chk("arb.if_valid", {31'b0, if_valid}, 32'h1);
        chk("arb.if_rdata", if_rdata, 32'h2222_2222);
        chk("arb.d2_req",   {31'b0, mem_req}, 32'h1);
        chk("arb.d2_addr",  mem_addr, 32'h0000_0604);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3333_3333;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("arb.d2_valid", {31'b0, d_valid}, 32'h1);
        chk("arb.d2_rdata", d_rdata, 32'h3333_3333);
        d_read = 1'b0;
        tick();

        // Misaligned word load
        d_read = 1'b1;
        d_op   = 3'b010;
        d_addr = 32'h0000_0402;
        #1;
        chk("mis.no_req", {31'b0, mem_req}, 32'h0);
        chk("mis.stall",  {31'b0, d_stall}, 32'h1);
        tick();
        #1;
        chk("mis.valid", {31'b0, d_valid}, 32'h1);
        chk("mis.err",   {31'b0, d_err}, 32'h1);
        chk("mis.rdata", d_rdata, 32'h0);
        chk("mis.no_req2", {31'b0, mem_req}, 32'h0);
        d_read = 1'b0;
        tick();
        #1;
        chk("mis.pulse_v", {31'b0, d_valid}, 32'h0);
        chk("mis.pulse_e", {31'b0, d_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
